// File: rtl/mem_data_mask_if.sv
// ============================================================================
// mem_data_mask_if : load-data path bundle between the memory read port and
//                    the load extraction/extension block.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_data_mask_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic [2:0]            inst_func_in;
  logic [1:0]            byte_addr_in;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;

  modport master (
    output data_in, inst_func_in, byte_addr_in, valid_in,
    input  data_out, valid_out
  );

  modport slave (
    input  data_in, inst_func_in, byte_addr_in, valid_in,
    output data_out, valid_out
  );
endinterface

`default_nettype wire

// File: rtl/mem_data_mask.sv
// ============================================================================
// mem_data_mask : RISC-V load byte/halfword/word extraction with sign/zero
//                 extension. Define MEM_MASK_REG_OUT_EN for registered outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_data_mask #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_data_mask_if.slave        bus
);

  localparam logic [2:0] C_LB  = 3'b000;
  localparam logic [2:0] C_LH  = 3'b001;
  localparam logic [2:0] C_LW  = 3'b010;
  localparam logic [2:0] C_LBU = 3'b100;
  localparam logic [2:0] C_LHU = 3'b101;

  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] result_d;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    result_d = '0;

    case (bus.byte_addr_in)
      2'd0:    byte_sel = bus.data_in[7:0];
      2'd1:    byte_sel = bus.data_in[15:8];
      2'd2:    byte_sel = bus.data_in[23:16];
      default: byte_sel = bus.data_in[31:24];
    endcase

    // Address 3 would straddle the word; it reuses the upper halfword.
    case (bus.byte_addr_in)
      2'd0:    half_sel = bus.data_in[15:0];
      2'd1:    half_sel = bus.data_in[23:8];
      default: half_sel = bus.data_in[31:16];
    endcase

    case (bus.inst_func_in)
      C_LB:    result_d = {{24{byte_sel[7]}}, byte_sel};
      C_LBU:   result_d = {24'h000000, byte_sel};
      C_LH:    result_d = {{16{half_sel[15]}}, half_sel};
      C_LHU:   result_d = {16'h0000, half_sel};
      C_LW:    result_d = bus.data_in;
      default: result_d = '0;
    endcase
  end

`ifdef MEM_MASK_REG_OUT_EN
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.valid_in;
      if (bus.valid_in) begin
        data_q <= result_d;
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign bus.data_out  = result_d;
  assign bus.valid_out = bus.valid_in;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_data_mask.sv
// ============================================================================
// tb_mem_data_mask : table-driven and scoreboard check of mem_data_mask in
//                    either output mode (MEM_MASK_REG_OUT_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_data_mask;

  logic clk;
  logic rst;

  mem_data_mask_if #(.DATA_WIDTH(32)) bus ();

  mem_data_mask #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  f;
    logic [1:0]  a;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        v;
  } exp_t;

  vec_t tbl [24];
  exp_t exp_q [$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [31:0] held_q = 32'h0;

`ifdef MEM_MASK_REG_OUT_EN
  localparam bit REG_MODE = 1'b1;
`else
  localparam bit REG_MODE = 1'b0;
`endif

  // Independent reference: shift-based extraction.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [2:0] f,
                                        input logic [1:0] a);
    logic [31:0] sh;
    if (f[1:0] == 2'b01 && a == 2'd3) sh = d >> 16;
    else                              sh = d >> (8 * a);
    case (f)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      3'b010:  return d;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one beat, queue its expectation, compare when the result is due.
  task automatic run(input string name, input logic [31:0] d, input logic [2:0] f,
                     input logic [1:0] a, input logic v);
    exp_t e;
    e.v = v;
    if (!REG_MODE || v) e.d = model(d, f, a);
    else                e.d = held_q;
    if (v) held_q = e.d;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.data_in      = d;
    bus.inst_func_in = f;
    bus.byte_addr_in = a;
    bus.valid_in     = v;
    if (REG_MODE) @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({name, ".data"}, bus.data_out, e.d);
    chk({name, ".valid"}, {31'h0, bus.valid_out}, {31'h0, e.v});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'hDEADBEEF, 3'b000, 2'd0, 32'hFFFFFFEF};
    tbl[1]  = '{32'hDEADBEEF, 3'b000, 2'd1, 32'hFFFFFFBE};
    tbl[2]  = '{32'hDEADBEEF, 3'b000, 2'd2, 32'hFFFFFFAD};
    tbl[3]  = '{32'hDEADBEEF, 3'b000, 2'd3, 32'hFFFFFFDE};
    tbl[4]  = '{32'hDEADBEEF, 3'b100, 2'd0, 32'h000000EF};
    tbl[5]  = '{32'hDEADBEEF, 3'b100, 2'd1, 32'h000000BE};
    tbl[6]  = '{32'hDEADBEEF, 3'b100, 2'd2, 32'h000000AD};
    tbl[7]  = '{32'hDEADBEEF, 3'b100, 2'd3, 32'h000000DE};
    tbl[8]  = '{32'hDEADBEEF, 3'b001, 2'd0, 32'hFFFFBEEF};
    tbl[9]  = '{32'hDEADBEEF, 3'b001, 2'd1, 32'hFFFFADBE};
    tbl[10] = '{32'hDEADBEEF, 3'b001, 2'd2, 32'hFFFFDEAD};
    tbl[11] = '{32'hDEADBEEF, 3'b001, 2'd3, 32'hFFFFDEAD};
    tbl[12] = '{32'hDEADBEEF, 3'b101, 2'd0, 32'h0000BEEF};
    tbl[13] = '{32'hDEADBEEF, 3'b101, 2'd1, 32'h0000ADBE};
    tbl[14] = '{32'hDEADBEEF, 3'b101, 2'd2, 32'h0000DEAD};
    tbl[15] = '{32'hDEADBEEF, 3'b101, 2'd3, 32'h0000DEAD};
    tbl[16] = '{32'h12345678, 3'b010, 2'd0, 32'h12345678};
    tbl[17] = '{32'h12345678, 3'b010, 2'd1, 32'h12345678};
    tbl[18] = '{32'h12345678, 3'b010, 2'd2, 32'h12345678};
    tbl[19] = '{32'h12345678, 3'b010, 2'd3, 32'h12345678};
    tbl[20] = '{32'h12345678, 3'b011, 2'd0, 32'h00000000};
    tbl[21] = '{32'h12345678, 3'b110, 2'd1, 32'h00000000};
    tbl[22] = '{32'h12345678, 3'b111, 2'd2, 32'h00000000};
    tbl[23] = '{32'h0000007F, 3'b000, 2'd0, 32'h0000007F};

    bus.data_in      = 32'h0;
    bus.inst_func_in = 3'b000;
    bus.byte_addr_in = 2'd0;
    bus.valid_in     = 1'b0;
    rst = 1'b1;
    #3;
    chk("reset.data", bus.data_out, 32'h0);
    chk("reset.valid", {31'h0, bus.valid_out}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Fixed expectations straight from the table, not from the model.
    for (int i = 0; i < 24; i++) begin
      exp_t e;
      e.d = tbl[i].exp;
      e.v = 1'b1;
      held_q = tbl[i].exp;
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.data_in      = tbl[i].d;
      bus.inst_func_in = tbl[i].f;
      bus.byte_addr_in = tbl[i].a;
      bus.valid_in     = 1'b1;
      if (REG_MODE) @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("tbl%0d.data", i), bus.data_out, e.d);
      chk($sformatf("tbl%0d.valid", i), {31'h0, bus.valid_out}, {31'h0, e.v});
    end

    for (int i = 0; i < 10; i++) begin
      logic [2:0] fs [5];
      fs = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      run($sformatf("rnd%0d", i), $urandom, fs[$urandom_range(0, 4)],
          2'($urandom_range(0, 3)), 1'b1);
    end

    // Valid beat then an idle beat: registered data must hold.
    run("lb_a1", 32'hDEADBEEF, 3'b000, 2'd1, 1'b1);
    run("idle_hold", 32'h12345678, 3'b010, 2'd0, 1'b0);
    run("idle_hold2", 32'h0000807F, 3'b001, 2'd0, 1'b0);

    // Asynchronous reset between edges with a result already captured.
    @(posedge clk); #1;
    bus.data_in = 32'h12345678; bus.inst_func_in = 3'b010;
    bus.byte_addr_in = 2'd0;   bus.valid_in = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst.data", bus.data_out, REG_MODE ? 32'h0 : 32'h12345678);
    chk("async_rst.valid", {31'h0, bus.valid_out}, {31'h0, !REG_MODE});
    bus.valid_in = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    held_q = 32'h0;
    run("post_rst_idle", 32'hCAFEF00D, 3'b100, 2'd2, 1'b0);
    run("post_rst_first", 32'hCAFEF00D, 3'b101, 2'd3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
